// File: rtl/image_pkg.sv
// Shared definitions for the image loader: pixel/word widths, default
// frame size and the loader state encoding.
package image_pkg;

  localparam int unsigned IMAGE_WIDTH_DEFAULT = 28;
  localparam int unsigned PIXEL_W             = 8;
  localparam int unsigned WORD_W_DEFAULT      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } loader_state_t;

endpackage

// File: rtl/image_loader_if.sv
// Byte-stream handshake feeding the image loader: the producer drives
// data/valid/last, the loader answers with ready.
interface image_loader_if;
  import image_pkg::*;

  logic [PIXEL_W-1:0] data;
  logic               valid;
  logic               last;
  logic               ready;

  modport master (output data, output valid, output last, input  ready);
  modport slave  (input  data, input  valid, input  last, output ready);

endinterface

// File: rtl/image_loader.sv
// Loads one IMAGE_WIDTH x IMAGE_WIDTH frame of signed bytes from a
// valid/ready stream and presents it as sign-extended words until released.
module image_loader
  import image_pkg::*;
#(
  parameter int unsigned IMAGE_WIDTH = IMAGE_WIDTH_DEFAULT,
  parameter int unsigned WORD_W      = WORD_W_DEFAULT
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [PIXEL_W-1:0]                         in_data,
  input  logic                                       in_valid,
  input  logic                                       in_last,
  output logic                                       in_ready,
  output logic [IMAGE_WIDTH*IMAGE_WIDTH*WORD_W-1:0]  image_data,
  output logic                                       image_valid,
  // "release" is a reserved SV keyword, hence the renamed port
  input  logic                                       frame_release,
  output logic                                       len_err
);

  localparam int unsigned N     = IMAGE_WIDTH * IMAGE_WIDTH;
  localparam int unsigned IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  loader_state_t      state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic               len_err_next;
  logic               wr_en;
  logic [PIXEL_W-1:0] pix [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      len_err <= 1'b0;
      for (int unsigned i = 0; i < N; i++) pix[i] <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      len_err <= len_err_next;
      if (wr_en) pix[idx] <= in_data;
    end
  end

  // Outputs depend only on the registered state, never on in_valid.
  assign in_ready    = (state == LOAD);
  assign image_valid = (state == FULL);

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    len_err_next = 1'b0;
    wr_en        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
        end
      end
      LOAD: begin
        if (start) begin
          idx_next = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (in_last) begin
              state_next = FULL;
            end else begin
              state_next   = IDLE;
              len_err_next = 1'b1;
            end
          end else if (in_last) begin
            idx_next     = '0;
            state_next   = IDLE;
            len_err_next = 1'b1;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      FULL: begin
        if (start) begin
          state_next = LOAD;
          idx_next   = '0;
        end else if (frame_release) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    image_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      image_data[i*WORD_W +: WORD_W] = {{(WORD_W-PIXEL_W){pix[i][PIXEL_W-1]}}, pix[i]};
    end
  end

endmodule
